// File: rtl/pipe_collision_detect_if.sv
// Bus between the pipe store / renderer side and the collision detector.
// The master drives the round control, bird position and in-scope pipe.
// The slave (the detector) returns the stop flag, the hit class, the gap
// bounds and the one-hot state.
interface pipe_collision_detect_if;
  logic       Start;
  logic       Ack;
  logic       Tick;
  logic [9:0] Bird_Y;
  logic [2:0] Pipe_Sel;
  logic [9:0] X_L;
  logic [9:0] X_R;

  logic       Stop;
  logic [1:0] Hit_Type;
  logic [9:0] Gap_Top;
  logic [9:0] Gap_Bot;
  logic       Q_Idle;
  logic       Q_Grace;
  logic       Q_Armed;
  logic       Q_Hit;

  modport master (
    output Start, Ack, Tick, Bird_Y, Pipe_Sel, X_L, X_R,
    input  Stop, Hit_Type, Gap_Top, Gap_Bot, Q_Idle, Q_Grace, Q_Armed, Q_Hit
  );

  modport slave (
    input  Start, Ack, Tick, Bird_Y, Pipe_Sel, X_L, X_R,
    output Stop, Hit_Type, Gap_Top, Gap_Bot, Q_Idle, Q_Grace, Q_Armed, Q_Hit
  );
endinterface

// File: rtl/pipe_collision_detect.sv
// Bird-versus-pipe/ground/ceiling collision detector. Once per frame tick
// while armed it checks the bird box against the in-scope pipe and the
// screen limits, raises Stop on a hit and holds it until acknowledged.
// A short grace period after Start suppresses hits while the round begins.
module pipe_collision_detect #(
  parameter int unsigned BIRD_X_L    = 210,
  parameter int unsigned BIRD_X_R    = 229,
  parameter int unsigned BIRD_H      = 20,
  parameter int unsigned GAP_H       = 120,
  parameter int unsigned GROUND_Y    = 440,
  parameter int unsigned GRACE_TICKS = 8,
  parameter int unsigned GAP0        = 100,
  parameter int unsigned GAP1        = 220,
  parameter int unsigned GAP2        = 60,
  parameter int unsigned GAP3        = 300,
  parameter int unsigned GAP4        = 160
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_collision_detect_if.slave bus
);

  // Hit classes as reported on Hit_Type.
  localparam logic [1:0] HIT_NONE    = 2'b00;
  localparam logic [1:0] HIT_PIPE    = 2'b01;
  localparam logic [1:0] HIT_GROUND  = 2'b10;
  localparam logic [1:0] HIT_CEILING = 2'b11;

  // Constants widened once so every comparison below is width-matched.
  localparam logic [10:0] BIRD_X_L_W  = 11'(BIRD_X_L);
  localparam logic [10:0] BIRD_X_R_W  = 11'(BIRD_X_R);
  localparam logic [10:0] BIRD_H_W    = 11'(BIRD_H);
  localparam logic [10:0] GROUND_Y_W  = 11'(GROUND_Y);
  localparam logic [9:0]  GAP_SPAN_W  = 10'(GAP_H - 1);
  localparam logic [9:0]  SCREEN_W    = 10'd640;
  localparam logic [3:0]  GRACE_INIT  = 4'(GRACE_TICKS);
  localparam logic [9:0]  GAP0_W      = 10'(GAP0);
  localparam logic [9:0]  GAP1_W      = 10'(GAP1);
  localparam logic [9:0]  GAP2_W      = 10'(GAP2);
  localparam logic [9:0]  GAP3_W      = 10'(GAP3);
  localparam logic [9:0]  GAP4_W      = 10'(GAP4);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_GRACE = 4'b0010,
    S_ARMED = 4'b0100,
    S_HIT   = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  grace_q, grace_d;
  logic [1:0]  hit_type_q, hit_type_d;
  logic        stop_q, stop_d;
  logic [9:0]  gap_top_q, gap_top_d;
  logic [9:0]  gap_bot_q, gap_bot_d;
  logic        pipe_valid_q, pipe_valid_d;

  logic [10:0] bird_bot;
  logic        ground_hit;
  logic        ceiling_hit;
  logic        pipe_on_screen;
  logic        x_overlap;
  logic        v_miss;
  logic        pipe_hit;
  logic [1:0]  eval_type;

  // Gap table lookup for the in-scope pipe; unknown indices disable the pipe.
  always_comb begin
    pipe_valid_d = 1'b1;
    case (bus.Pipe_Sel)
      3'd0:    gap_top_d = GAP0_W;
      3'd1:    gap_top_d = GAP1_W;
      3'd2:    gap_top_d = GAP2_W;
      3'd3:    gap_top_d = GAP3_W;
      3'd4:    gap_top_d = GAP4_W;
      default: begin
        gap_top_d    = 10'd0;
        pipe_valid_d = 1'b0;
      end
    endcase
    gap_bot_d = gap_top_d + GAP_SPAN_W;
  end

  // Collision terms for the current bird position against the registered gap.
  always_comb begin
    bird_bot       = {1'b0, bus.Bird_Y} + BIRD_H_W - 11'd1;
    ground_hit     = (bird_bot >= GROUND_Y_W);
    ceiling_hit    = (bus.Bird_Y == 10'd0);
    pipe_on_screen = (bus.X_L < SCREEN_W);
    x_overlap      = ({1'b0, bus.X_L} <= BIRD_X_R_W) &&
                     ({1'b0, bus.X_R} >= BIRD_X_L_W);
    v_miss         = (bus.Bird_Y < gap_top_q) ||
                     (bird_bot > {1'b0, gap_bot_q});
    pipe_hit       = pipe_valid_q && pipe_on_screen && x_overlap && v_miss;
    if (ground_hit)
      eval_type = HIT_GROUND;
    else if (ceiling_hit)
      eval_type = HIT_CEILING;
    else if (pipe_hit)
      eval_type = HIT_PIPE;
    else
      eval_type = HIT_NONE;
  end

  // State register plus grace counter, hit class, stop flag and gap bounds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grace_q      <= 4'd0;
      hit_type_q   <= HIT_NONE;
      stop_q       <= 1'b0;
      gap_top_q    <= GAP0_W;
      gap_bot_q    <= GAP0_W + GAP_SPAN_W;
      pipe_valid_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grace_q      <= grace_d;
      hit_type_q   <= hit_type_d;
      stop_q       <= stop_d;
      gap_top_q    <= gap_top_d;
      gap_bot_q    <= gap_bot_d;
      pipe_valid_q <= pipe_valid_d;
    end
  end

  // Next-state logic: round start, grace countdown, armed evaluation, ack.
  always_comb begin
    state_d    = state_q;
    grace_d    = grace_q;
    hit_type_d = hit_type_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d    = S_GRACE;
          grace_d    = GRACE_INIT;
          hit_type_d = HIT_NONE;
        end
      end
      S_GRACE: begin
        if (bus.Tick) begin
          if (grace_q <= 4'd1) begin
            grace_d = 4'd0;
            state_d = S_ARMED;
          end else begin
            grace_d = grace_q - 4'd1;
          end
        end
      end
      S_ARMED: begin
        if (bus.Tick && (eval_type != HIT_NONE)) begin
          state_d    = S_HIT;
          hit_type_d = eval_type;
        end
      end
      S_HIT: begin
        if (bus.Ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: one-hot state straight out, Stop follows the HIT state.
  always_comb begin
    stop_d      = (state_d == S_HIT);
    bus.Q_Idle  = state_q[0];
    bus.Q_Grace = state_q[1];
    bus.Q_Armed = state_q[2];
    bus.Q_Hit   = state_q[3];
  end

  assign bus.Stop     = stop_q;
  assign bus.Hit_Type = hit_type_q;
  assign bus.Gap_Top  = gap_top_q;
  assign bus.Gap_Bot  = gap_bot_q;

endmodule

// File: tb/tb_pipe_collision_detect.sv
// Directed bench for pipe_collision_detect. Inputs change and outputs are
// sampled on the falling clock edge, well away from the active rising edge.
module tb_pipe_collision_detect;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipe_collision_detect_if bus ();

  pipe_collision_detect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame tick, leaving the outputs of that edge visible on return.
  task automatic pulseTick();
    bus.Tick = 1'b1;
    @(negedge clk);
    bus.Tick = 1'b0;
  endtask

  // Start a round and run the full grace period so the block ends ARMED.
  task automatic applyStimulus();
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (8) pulseTick();
  endtask

  // Acknowledge a hit for one cycle.
  task automatic ackHit();
    bus.Ack = 1'b1;
    @(negedge clk);
    bus.Ack = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Ack      = 1'b0;
    bus.Tick     = 1'b0;
    bus.Bird_Y   = 10'd0;
    bus.Pipe_Sel = 3'd0;
    bus.X_L      = 10'd640;
    bus.X_R      = 10'd700;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_q_idle", 32'(bus.Q_Idle), 1);
    checkOutput("rst_q_other", 32'({bus.Q_Grace, bus.Q_Armed, bus.Q_Hit}), 0);
    checkOutput("rst_stop", 32'(bus.Stop), 0);
    checkOutput("rst_hit_type", 32'(bus.Hit_Type), 0);
    checkOutput("rst_gap_top", 32'(bus.Gap_Top), 100);
    checkOutput("rst_gap_bot", 32'(bus.Gap_Bot), 219);
    reset = 1'b0;
    @(negedge clk);

    // Grace period with the bird on the ceiling row
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    checkOutput("grace_entry", 32'(bus.Q_Grace), 1);
    for (int i = 1; i <= 7; i++) begin
      pulseTick();
      checkOutput("grace_stop", 32'(bus.Stop), 0);
      checkOutput("grace_state", 32'(bus.Q_Grace), 1);
    end
    pulseTick();
    checkOutput("grace_armed", 32'(bus.Q_Armed), 1);
    checkOutput("grace_armed_stop", 32'(bus.Stop), 0);
    pulseTick();
    checkOutput("ceil_stop", 32'(bus.Stop), 1);
    checkOutput("ceil_type", 32'(bus.Hit_Type), 3);
    checkOutput("ceil_q_hit", 32'(bus.Q_Hit), 1);

    // Asynchronous reset while in HIT
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_stop", 32'(bus.Stop), 0);
    checkOutput("async_rst_idle", 32'(bus.Q_Idle), 1);
    checkOutput("async_rst_hit", 32'(bus.Q_Hit), 0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("post_rst_type", 32'(bus.Hit_Type), 0);
    checkOutput("post_rst_gap", 32'(bus.Gap_Top), 100);

    // Pipe 1 overlapping the bird, gap 220..339
    bus.Pipe_Sel = 3'd1;
    bus.X_L      = 10'd220;
    bus.X_R      = 10'd281;
    bus.Bird_Y   = 10'd230;
    applyStimulus();
    checkOutput("p1_gap_top", 32'(bus.Gap_Top), 220);
    checkOutput("p1_gap_bot", 32'(bus.Gap_Bot), 339);
    pulseTick();
    checkOutput("p1_in_gap_stop", 32'(bus.Stop), 0);
    checkOutput("p1_in_gap_armed", 32'(bus.Q_Armed), 1);
    ackHit();
    checkOutput("ack_when_armed", 32'(bus.Q_Armed), 1);
    bus.Bird_Y = 10'd210;
    @(negedge clk);
    checkOutput("no_tick_no_hit", 32'(bus.Stop), 0);
    pulseTick();
    checkOutput("p1_hit_stop", 32'(bus.Stop), 1);
    checkOutput("p1_hit_type", 32'(bus.Hit_Type), 1);

    // Tick while in HIT is ignored, then acknowledge
    bus.Bird_Y = 10'd0;
    pulseTick();
    checkOutput("hit_tick_type", 32'(bus.Hit_Type), 1);
    checkOutput("hit_tick_state", 32'(bus.Q_Hit), 1);
    ackHit();
    checkOutput("ack_idle", 32'(bus.Q_Idle), 1);
    checkOutput("ack_stop", 32'(bus.Stop), 0);
    checkOutput("ack_type_held", 32'(bus.Hit_Type), 1);

    // Ground beats pipe when both fire
    bus.Bird_Y = 10'd230;
    applyStimulus();
    checkOutput("round_clears_type", 32'(bus.Hit_Type), 0);
    bus.Bird_Y = 10'd425;
    pulseTick();
    checkOutput("ground_prio_type", 32'(bus.Hit_Type), 2);
    checkOutput("ground_prio_stop", 32'(bus.Stop), 1);
    ackHit();

    // Off-screen wrap position and clamped left edge
    bus.Pipe_Sel = 3'd0;
    bus.X_L      = 10'd640;
    bus.X_R      = 10'd720;
    bus.Bird_Y   = 10'd10;
    applyStimulus();
    pulseTick();
    checkOutput("wrap_no_hit", 32'(bus.Stop), 0);
    bus.X_L = 10'd0;
    bus.X_R = 10'd229;
    pulseTick();
    checkOutput("clamp_hit_type", 32'(bus.Hit_Type), 1);
    ackHit();
    bus.X_R = 10'd209;
    applyStimulus();
    pulseTick();
    checkOutput("xr_209_no_hit", 32'(bus.Stop), 0);

    // Invalid pipe index disables the pipe term; ground boundary row
    bus.Pipe_Sel = 3'd6;
    bus.X_L      = 10'd220;
    bus.X_R      = 10'd281;
    @(negedge clk);
    checkOutput("sel6_gap_top", 32'(bus.Gap_Top), 0);
    checkOutput("sel6_gap_bot", 32'(bus.Gap_Bot), 119);
    bus.Bird_Y = 10'd210;
    pulseTick();
    checkOutput("sel6_no_pipe", 32'(bus.Stop), 0);
    bus.Bird_Y = 10'd420;
    pulseTick();
    checkOutput("ground_439_no_hit", 32'(bus.Stop), 0);
    bus.Bird_Y = 10'd421;
    pulseTick();
    checkOutput("ground_440_type", 32'(bus.Hit_Type), 2);

    // Start held through Ack re-enters GRACE one cycle after IDLE
    bus.Start = 1'b1;
    bus.Ack   = 1'b1;
    @(negedge clk);
    bus.Ack = 1'b0;
    checkOutput("held_start_idle", 32'(bus.Q_Idle), 1);
    checkOutput("held_start_stop", 32'(bus.Stop), 0);
    @(negedge clk);
    bus.Start = 1'b0;
    checkOutput("held_start_grace", 32'(bus.Q_Grace), 1);
    checkOutput("held_start_clear", 32'(bus.Hit_Type), 0);
    bus.Bird_Y = 10'd0;
    repeat (8) pulseTick();
    pulseTick();
    checkOutput("regrace_ceil", 32'(bus.Hit_Type), 3);
    ackHit();

    // Tick coincident with Start is not counted toward grace
    bus.Start = 1'b1;
    bus.Tick  = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Tick  = 1'b0;
    checkOutput("start_tick_grace", 32'(bus.Q_Grace), 1);
    repeat (7) pulseTick();
    checkOutput("start_tick_7", 32'(bus.Q_Grace), 1);
    pulseTick();
    checkOutput("start_tick_8", 32'(bus.Q_Armed), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
